// File: rtl/nes_joypad_serializer_pkg.sv
// Shared types and button bit positions for the NES joypad serializer.
// Bit order matches the 4021 shift order seen by the NES: A first, Right last.
package nes_joypad_pkg;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef logic [7:0] nes_buttons_t;

endpackage

// File: rtl/nes_joypad_serializer_if.sv
// NES controller-port bundle: strobe and clock from the core, serial data back.
// master = NES core side, slave = joypad serializer side.
interface nes_joy_if;
    import nes_joypad_pkg::*;

    logic i_strobe;
    logic i_joy_clock;
    logic o_data;

    modport master (output i_strobe, output i_joy_clock, input o_data);
    modport slave  (input i_strobe, input i_joy_clock, output o_data);

endinterface

// File: rtl/nes_joypad_serializer_debounce.sv
// Single-bit debouncer: a new level is accepted once it has differed from the
// stable level for 2^C_bits consecutive cycles; any shorter disagreement is dropped.
module btn_debounce
    import nes_joypad_pkg::*;
#(
    parameter int C_bits = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw,
    output logic o_stable
);

    localparam logic [C_bits-1:0] L_MAX = '1;

    logic [C_bits-1:0] r_cnt;
    logic              r_stable;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (i_raw == r_stable) begin
            r_cnt <= '0;
        end else if (r_cnt != L_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_stable <= i_raw;
            r_cnt    <= '0;
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/nes_joypad_serializer.sv
// NES controller-port emulation: merges onboard and USB buttons into a 4021-style
// shift register read by the NES core. Optional turbo via macro JOYPAD_TURBO_EN.
module nes_joypad_serializer
    import nes_joypad_pkg::*;
#(
    parameter int C_debounce_bits = 16,
    parameter bit C_fill_bit      = 1'b1,
    parameter int C_turbo_div     = 21
) (
    input  logic         clk,
    input  logic         reset_n,
    input  nes_buttons_t i_btn,
    input  nes_buttons_t i_usb_btn,
`ifdef JOYPAD_TURBO_EN
    input  nes_buttons_t i_turbo_mask,
`endif
    output nes_buttons_t o_buttons,
    nes_joy_if.slave     joy
);

    nes_buttons_t r_btn_s1, r_btn_s2;
    nes_buttons_t r_usb_s1, r_usb_s2;
    nes_buttons_t w_btn_db;
    nes_buttons_t w_merged;
    nes_buttons_t w_merged_t;
    nes_buttons_t r_buttons;
    nes_buttons_t r_sr;
    logic         r_last_jc;

    // Both button sources are asynchronous to clk
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
            r_usb_s1 <= '0;
            r_usb_s2 <= '0;
        end else begin
            r_btn_s1 <= i_btn;
            r_btn_s2 <= r_btn_s1;
            r_usb_s1 <= i_usb_btn;
            r_usb_s2 <= r_usb_s1;
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_db
        btn_debounce #(.C_bits(C_debounce_bits)) u_db (
            .clk      (clk),
            .reset_n  (reset_n),
            .i_raw    (r_btn_s2[g]),
            .o_stable (w_btn_db[g])
        );
    end

    assign w_merged = w_btn_db | r_usb_s2;

`ifdef JOYPAD_TURBO_EN
    logic [C_turbo_div:0] r_turbo_cnt;
    logic                 w_phase;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_turbo_cnt <= '0;
        else          r_turbo_cnt <= r_turbo_cnt + 1'b1;
    end

    // Masked buttons are forced released during the low half of the turbo period
    assign w_phase    = r_turbo_cnt[C_turbo_div];
    assign w_merged_t = w_merged & ~(i_turbo_mask & {8{~w_phase}});
`else
    assign w_merged_t = w_merged;
`endif

    // Strobe reloads continuously and takes priority over a coincident read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buttons <= '0;
            r_sr      <= '0;
            r_last_jc <= 1'b0;
        end else begin
            r_buttons <= w_merged_t;
            r_last_jc <= joy.i_joy_clock;
            if (joy.i_strobe)
                r_sr <= w_merged_t;
            else if (r_last_jc && !joy.i_joy_clock)
                r_sr <= {C_fill_bit, r_sr[7:1]};
        end
    end

    assign o_buttons  = r_buttons;
    assign joy.o_data = r_sr[0];

endmodule

// File: tb/tb_nes_joypad_serializer.sv
// Self-checking bench for nes_joypad_serializer: per-cycle behavioural model plus
// literal expectations for reset, serial read, debounce, strobe, snapshot and turbo.
module tb_nes_joypad_serializer;
    import nes_joypad_pkg::*;

    localparam int DB   = 4;
    localparam bit FILL = 1'b1;
    localparam int TDIV = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    nes_buttons_t btn = '0;
    nes_buttons_t usb = '0;
    nes_buttons_t o_buttons;
`ifdef JOYPAD_TURBO_EN
    nes_buttons_t tmask = '0;
`endif

    nes_joy_if joy ();

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nes_joypad_serializer #(
        .C_debounce_bits (DB),
        .C_fill_bit      (FILL),
        .C_turbo_div     (TDIV)
    ) dut (
        .clk          (clk),
        .reset_n      (rst_n),
        .i_btn        (btn),
        .i_usb_btn    (usb),
`ifdef JOYPAD_TURBO_EN
        .i_turbo_mask (tmask),
`endif
        .o_buttons    (o_buttons),
        .joy          (joy.slave)
    );

    // ---------------- behavioural model ----------------
    nes_buttons_t m_b1, m_b2, m_u1, m_u2;  // input seen one / two edges ago
    nes_buttons_t m_stable;
    int           m_run [8];
    bit           m_sr [$];
    bit           m_last_jc;
    int           m_cyc;
    bit           exp_data;
    nes_buttons_t exp_buttons;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_b1 = '0; m_b2 = '0; m_u1 = '0; m_u2 = '0;
            m_stable = '0;
            for (int b = 0; b < 8; b++) m_run[b] = 0;
            m_sr = {};
            for (int b = 0; b < 8; b++) m_sr.push_back(1'b0);
            m_last_jc = 1'b0;
            m_cyc = 0;
            exp_data = 1'b0;
            exp_buttons = '0;
        end else begin
            nes_buttons_t merged;
            merged = m_stable | m_u2;
`ifdef JOYPAD_TURBO_EN
            if (((m_cyc >> TDIV) & 1) == 0) merged = merged & ~tmask;
`endif
            exp_buttons = merged;
            for (int b = 0; b < 8; b++) begin
                if (m_b2[b] != m_stable[b]) begin
                    m_run[b]++;
                    if (m_run[b] == (1 << DB)) begin
                        m_stable[b] = m_b2[b];
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            if (joy.i_strobe) begin
                m_sr = {};
                for (int b = 0; b < 8; b++) m_sr.push_back(merged[b]);
            end else if (m_last_jc && !joy.i_joy_clock) begin
                void'(m_sr.pop_front());
                m_sr.push_back(FILL);
            end
            m_last_jc = joy.i_joy_clock;
            exp_data = m_sr[0];
            m_b2 = m_b1; m_b1 = btn;
            m_u2 = m_u1; m_u1 = usb;
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        checks++;
        if (joy.o_data !== exp_data) begin
            failures++;
            $display("FAIL model_data t=%0t got=%b exp=%b", $time, joy.o_data, exp_data);
        end
        checks++;
        if (o_buttons !== exp_buttons) begin
            failures++;
            $display("FAIL model_buttons t=%0t got=%h exp=%h", $time, o_buttons, exp_buttons);
        end
    end

    // ---------------- literal checks and stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic read_bit();
        joy.i_joy_clock = 1'b1; tick();
        joy.i_joy_clock = 1'b0; tick();
    endtask

    initial begin
        logic [9:0]   seq;
        nes_buttons_t snap;
        int           toggles;
        logic         prev;

        joy.i_strobe = 1'b0;
        joy.i_joy_clock = 1'b0;

        // reset with USB buttons all pressed
        usb = 8'hFF;
        repeat (3) tick();
        chk("rst_data", {7'd0, joy.o_data}, 8'h00);
        chk("rst_buttons", o_buttons, 8'h00);
        rst_n = 1'b1;
        tick(); chk("rel_c1", o_buttons, 8'h00);
        tick(); chk("rel_c2", o_buttons, 8'h00);
        tick(); chk("rel_c3", o_buttons, 8'hFF);

        // serial read of 1000_0101 with two extra reads
        usb = 8'b1000_0101;
        joy.i_strobe = 1'b1; repeat (4) tick();
        joy.i_strobe = 1'b0; tick();
        seq = 10'b11_1000_0101;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("read%0d", i), {7'd0, joy.o_data}, {7'd0, seq[i]});
            read_bit();
        end

        // debounce: 10-cycle glitch ignored, long press accepted
        usb = 8'h00; repeat (6) tick();
        btn[0] = 1'b1; repeat (10) tick();
        btn[0] = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k % 10 == 0) chk("glitch", {7'd0, o_buttons[0]}, 8'h00);
        end
        btn[0] = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (k == 18) chk("db_before", {7'd0, o_buttons[0]}, 8'h00);
            if (k == 19) chk("db_after", {7'd0, o_buttons[0]}, 8'h01);
        end
        btn[0] = 1'b0; repeat (25) tick();
        chk("db_release", {7'd0, o_buttons[0]}, 8'h00);

        // strobe held: 3-cycle follow latency, no shift on coincident falling edge
        joy.i_strobe = 1'b1; repeat (4) tick();
        usb[0] = 1'b1;
        tick(); chk("follow1", {7'd0, joy.o_data}, 8'h00);
        tick(); chk("follow2", {7'd0, joy.o_data}, 8'h00);
        tick(); chk("follow3", {7'd0, joy.o_data}, 8'h01);
        usb = 8'b0000_0010; repeat (4) tick();
        chk("strobe_b0", {7'd0, joy.o_data}, 8'h00);
        read_bit();
        chk("no_shift", {7'd0, joy.o_data}, 8'h00);
        joy.i_strobe = 1'b0; tick();
        read_bit();
        chk("after_shift", {7'd0, joy.o_data}, 8'h01);

        // snapshot survives button changes after strobe
        snap = 8'hA5; usb = snap;
        joy.i_strobe = 1'b1; repeat (4) tick();
        joy.i_strobe = 1'b0; tick();
        read_bit(); read_bit();
        usb = 8'h5A; repeat (4) tick();
        for (int i = 2; i < 8; i++) begin
            chk($sformatf("snap%0d", i), {7'd0, joy.o_data}, {7'd0, snap[i]});
            read_bit();
        end

        // turbo on A, or constant A with the feature off
        usb = 8'h01; repeat (4) tick();
`ifdef JOYPAD_TURBO_EN
        tmask = 8'h01;
        repeat (4) tick();
        toggles = 0;
        prev = o_buttons[0];
        for (int k = 0; k < 32; k++) begin
            tick();
            if (o_buttons[0] != prev) toggles++;
            prev = o_buttons[0];
        end
        chk("turbo_toggles", toggles[7:0], 8'd4);
        tmask = 8'h00;
`else
        toggles = 0;
        prev = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k % 5 == 0) chk("no_turbo", {7'd0, o_buttons[0]}, 8'h01);
        end
`endif

        // reset mid-frame, then recover on the next strobe
        usb = 8'h03;
        joy.i_strobe = 1'b1; repeat (4) tick();
        joy.i_strobe = 1'b0; tick();
        read_bit();
        rst_n = 1'b0; tick(); tick();
        chk("midrst_data", {7'd0, joy.o_data}, 8'h00);
        rst_n = 1'b1; repeat (3) tick();
        chk("midrst_hold", {7'd0, joy.o_data}, 8'h00);
        joy.i_strobe = 1'b1; tick();
        chk("midrst_recover", {7'd0, joy.o_data}, 8'h01);
        joy.i_strobe = 1'b0; tick();

        // randomized traffic checked by the model
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            joy.i_strobe = ($urandom_range(0, 15) == 0);
            joy.i_joy_clock = $urandom_range(0, 1);
            if (r < 8) usb = nes_buttons_t'($urandom);
            if (r == 8) btn = nes_buttons_t'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
